// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 target that turns command/data bytes into register-write strobes
// Optional CIPO loopback echo of the previous byte is enabled by defining SPI_CIPO_EN.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sck_i,
  input  logic        spi_copi_i,
  input  logic        spi_cs_i,
  output logic        reg_wr,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        frame_err
`ifdef SPI_CIPO_EN
  ,
  output logic        spi_cipo_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA_HI,
    DATA_LO,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_hist;
  logic                   cs_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      copi_sync <= '0;
      cs_sync   <= '1;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic       sck_s;
  logic       copi_s;
  logic       cs_s;
  logic       sck_rise;
  logic       cs_fall;
  logic       cs_rise;
  logic       bit_en;
  logic       byte_done;
  logic [7:0] byte_val;
  logic [2:0] bit_cnt;
  // Only the seven earlier bits need storing; the eighth is taken live from copi_s.
  logic [6:0] shift;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_hist;
  assign cs_fall   = ~cs_s & cs_hist;
  assign cs_rise   = cs_s & ~cs_hist;
  assign bit_en    = sck_rise & ~cs_s;
  assign byte_done = bit_en & (bit_cnt == 3'd7);
  assign byte_val  = {shift, copi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 3'd0;
      shift   <= 7'd0;
    end else if (cs_fall) begin
      bit_cnt <= 3'd0;
    end else if (bit_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= byte_val[6:0];
    end
  end

  state_t      state, state_n;
  logic [3:0]  addr, addr_n;
  logic        inc, inc_n;
  logic [7:0]  hi, hi_n;
  logic        wr_n;
  logic        err_n;
  logic [3:0]  reg_addr_n;
  logic [15:0] reg_data_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= 4'd0;
      inc       <= 1'b0;
      hi        <= 8'd0;
      reg_wr    <= 1'b0;
      reg_addr  <= 4'd0;
      reg_data  <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      inc       <= inc_n;
      hi        <= hi_n;
      reg_wr    <= wr_n;
      reg_addr  <= reg_addr_n;
      reg_data  <= reg_data_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    inc_n      = inc;
    hi_n       = hi;
    wr_n       = 1'b0;
    err_n      = 1'b0;
    reg_addr_n = reg_addr;
    reg_data_n = reg_data;
    // A deselect outranks any byte completing in the same cycle; that edge is gated off by cs_s anyway.
    if (cs_rise) begin
      state_n = IDLE;
      err_n   = (bit_cnt != 3'd0) || (state == DATA_LO);
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) state_n = CMD;
        end
        CMD: begin
          if (byte_done) begin
            if (byte_val[7]) begin
              state_n = DATA_HI;
              addr_n  = byte_val[3:0];
              inc_n   = byte_val[6];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        DATA_HI: begin
          if (byte_done) begin
            hi_n    = byte_val;
            state_n = DATA_LO;
          end
        end
        DATA_LO: begin
          if (byte_done) begin
            wr_n       = 1'b1;
            reg_addr_n = addr;
            reg_data_n = {hi, byte_val};
            addr_n     = addr + {3'd0, inc};
            state_n    = DATA_HI;
          end
        end
        IGNORE: begin
          state_n = IGNORE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

`ifdef SPI_CIPO_EN
  logic       sck_fall;
  logic [7:0] lb_shift;
  logic [7:0] lb_pend;
  logic       lb_full;

  assign sck_fall = ~sck_s & sck_hist;

  // A completed byte waits in lb_pend until the next SCK fall so its MSB is stable before the host samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb_shift <= 8'd0;
      lb_pend  <= 8'd0;
      lb_full  <= 1'b0;
    end else if (cs_fall) begin
      lb_shift <= 8'd0;
      lb_full  <= 1'b0;
    end else begin
      if (byte_done) begin
        lb_pend <= byte_val;
        lb_full <= 1'b1;
      end
      if (sck_fall && !cs_s) begin
        if (lb_full) begin
          lb_shift <= lb_pend;
          lb_full  <= 1'b0;
        end else begin
          lb_shift <= {lb_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_cipo_o = lb_shift[7] & ~cs_s;
`endif

endmodule
